// File: rtl/wb_sram8_ctrl.sv
// Wishbone B3 classic 32-bit slave that serialises each word access into big-endian byte
// cycles on a 512Kx8 asynchronous SRAM. All SRAM strobes and bus outputs are registered.
module wb_sram8_ctrl #(
  parameter int ADDR_WIDTH = 19,
  parameter int RD_CYCLES  = 2,
  parameter int WR_SETUP   = 1,
  parameter int WR_PULSE   = 2,
  parameter int WR_HOLD    = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] sram_adr_o,
  output logic [7:0]            sram_dat_o,
  input  logic [7:0]            sram_dat_i,
  output logic                  sram_dat_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_we_n_o,
  output logic                  sram_oe_n_o
);

  localparam int CW = 8;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] SU_LAST = CW'(WR_SETUP - 1);
  localparam logic [CW-1:0] PW_LAST = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(WR_HOLD - 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SU, WR_PW, WR_HD, ACK} state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-3:0]  wadr_q;
  logic [31:0]            wdat_q, dat_q;
  logic                   we_q, abort_q, ack_q;
  logic [3:0]             rem_q;
  logic [1:0]             lane_q;
  logic [CW-1:0]          cnt_q;
  logic [ADDR_WIDTH-1:0]  adr_q;
  logic [7:0]             sdat_q;
  logic                   doe_q, ce_n_q, we_n_q, oe_n_q;

  // Byte lane masks are indexed by byte offset: offset 0 is sel[3] / dat[31:24].
  logic [3:0]            sel_mask, src_mask, nxt_rem_d;
  logic                  req, src_we, byte_done, stop, start_d;
  logic [ADDR_WIDTH-3:0] src_adr;
  logic [31:0]           src_dat;
  logic [1:0]            nxt_lane_d;
  logic [7:0]            nxt_byte_d;

  logic unused;
  assign unused = ^{wb_adr_i[31:ADDR_WIDTH], wb_adr_i[1:0]};

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    byte_of = w[31:24];
      2'd1:    byte_of = w[23:16];
      2'd2:    byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] l,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (l)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  assign req = wb_cyc_i & wb_stb_i;

  // In IDLE the next byte comes straight from the bus; afterwards from the latched request.
  always_comb begin
    for (int i = 0; i < 4; i++) sel_mask[i] = wb_sel_i[3-i];
    src_mask   = (state_q == IDLE) ? sel_mask : rem_q;
    src_we     = (state_q == IDLE) ? wb_we_i : we_q;
    src_adr    = (state_q == IDLE) ? wb_adr_i[ADDR_WIDTH-1:2] : wadr_q;
    src_dat    = (state_q == IDLE) ? wb_dat_i : wdat_q;
    nxt_lane_d = 2'd0;
    for (int i = 3; i >= 0; i--) if (src_mask[i]) nxt_lane_d = 2'(i);
    nxt_rem_d  = src_mask & ~(4'b0001 << nxt_lane_d);
    nxt_byte_d = byte_of(src_dat, nxt_lane_d);
    byte_done  = ((state_q == RD) && (cnt_q == RD_LAST)) ||
                 ((state_q == WR_HD) && (cnt_q == HD_LAST));
    stop       = abort_q | ~wb_cyc_i;
    start_d    = ((state_q == IDLE) && req && (|src_mask)) ||
                 (byte_done && (|src_mask) && !stop);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      wadr_q  <= '0;
      wdat_q  <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      rem_q   <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      sdat_q  <= '0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      if (state_q == IDLE && req) begin
        we_q    <= wb_we_i;
        wadr_q  <= wb_adr_i[ADDR_WIDTH-1:2];
        wdat_q  <= wb_dat_i;
        dat_q   <= '0;
        abort_q <= 1'b0;
      end else if (state_q != IDLE && !wb_cyc_i) begin
        abort_q <= 1'b1;
      end

      if (state_q == RD && cnt_q == RD_LAST) dat_q <= put_byte(dat_q, lane_q, sram_dat_i);

      if (start_d) begin
        state_q <= src_we ? WR_SU : RD;
        lane_q  <= nxt_lane_d;
        rem_q   <= nxt_rem_d;
        cnt_q   <= '0;
        adr_q   <= {src_adr, nxt_lane_d};
        ce_n_q  <= 1'b0;
        we_n_q  <= 1'b1;
        oe_n_q  <= src_we;
        doe_q   <= src_we;
        if (src_we) sdat_q <= nxt_byte_d;
      end else begin
        case (state_q)
          IDLE: if (req) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
          RD, WR_HD: if (byte_done) begin
            // An abandoned cycle ends here without acknowledge.
            state_q <= stop ? IDLE : ACK;
            ack_q   <= !stop;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            doe_q   <= 1'b0;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
          WR_SU: if (cnt_q == SU_LAST) begin
            state_q <= WR_PW;
            we_n_q  <= 1'b0;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
          WR_PW: if (cnt_q == PW_LAST) begin
            state_q <= WR_HD;
            we_n_q  <= 1'b1;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
          ACK: begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wb_dat_o      = dat_q;
  assign wb_ack_o      = ack_q;
  assign sram_adr_o    = adr_q;
  assign sram_dat_o    = sdat_q;
  assign sram_dat_oe_o = doe_q;
  assign sram_ce_n_o   = ce_n_q;
  assign sram_we_n_o   = we_n_q;
  assign sram_oe_n_o   = oe_n_q;

endmodule
